// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data BRAM between the CPU and the CGRA.
// Round-robin arbitration with a bounded CGRA burst lock and read-data routing.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cgra_req,
  input  logic              cgra_we,
  input  logic [ADDR_W-1:0] cgra_addr,
  input  logic [DATA_W-1:0] cgra_wdata,
  input  logic              cgra_lock,
  output logic              cgra_gnt,
  output logic              cgra_rvalid,
  output logic [DATA_W-1:0] cgra_rdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);

  localparam int CNT_W = $clog2(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

  localparam logic G_CPU  = 1'b0;
  localparam logic G_CGRA = 1'b1;

  typedef enum logic [1:0] {
    ARB,
    LOCK,
    YIELD
  } state_t;

  state_t           state;
  logic             last_gnt;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       rd_owner;

  // Pick at most one winner per cycle from the current arbitration mode.
  always_comb begin
    cpu_gnt  = 1'b0;
    cgra_gnt = 1'b0;
    case (state)
      ARB: begin
        if (cpu_req && cgra_req) begin
          if (last_gnt == G_CGRA) cpu_gnt  = 1'b1;
          else                    cgra_gnt = 1'b1;
        end else begin
          cpu_gnt  = cpu_req;
          cgra_gnt = cgra_req;
        end
      end
      LOCK:    cgra_gnt = cgra_req;
      YIELD:   cpu_gnt  = cpu_req;
      default: ;
    endcase
  end

  // Steer the granted port onto the RAM pins; idle pins park at zero.
  always_comb begin
    mem_ena   = 1'b0;
    mem_wea   = 1'b0;
    mem_addra = '0;
    mem_dina  = '0;
    if (cpu_gnt) begin
      mem_ena   = 1'b1;
      mem_wea   = cpu_we;
      mem_addra = cpu_addr;
      mem_dina  = cpu_wdata;
    end else if (cgra_gnt) begin
      mem_ena   = 1'b1;
      mem_wea   = cgra_we;
      mem_addra = cgra_addr;
      mem_dina  = cgra_wdata;
    end
  end

  // Arbitration mode, round-robin pointer and burst fairness counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      last_gnt <= G_CGRA;
      lock_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (cpu_gnt) begin
            last_gnt <= G_CPU;
          end else if (cgra_gnt) begin
            last_gnt <= G_CGRA;
            if (cgra_lock) begin
              state    <= LOCK;
              lock_cnt <= '0;
            end
          end
        end
        LOCK: begin
          if (cgra_gnt) last_gnt <= G_CGRA;
          if (!cgra_lock) begin
            state    <= ARB;
            lock_cnt <= '0;
            last_gnt <= G_CGRA;
          end else begin
            if (lock_cnt != CNT_MAX)
              lock_cnt <= lock_cnt + CNT_W'(1);
            if (lock_cnt == CNT_MAX && cpu_req)
              state <= YIELD;
          end
        end
        YIELD: begin
          last_gnt <= G_CPU;
          if (cgra_lock && cgra_req) begin
            state    <= LOCK;
            lock_cnt <= '0;
          end else begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Remember who issued the read so the returning data goes back to them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_owner <= '0;
    else       rd_owner <= {cgra_gnt & ~cgra_we, cpu_gnt & ~cpu_we};
  end

  assign cpu_rvalid  = rd_owner[0];
  assign cgra_rvalid = rd_owner[1];
  assign cpu_rdata   = mem_douta;
  assign cgra_rdata  = mem_douta;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data BRAM (1-cycle read latency, 10-bit word address, 32-bit data) between the RISC-V core and the CGRA array. It sits between both masters and the data RAM, owns the RAM's `ena`/`wea`/`addra`/`dina` pins, and routes read data back to the requester that issued the read. Contention is resolved round-robin. The CGRA can lock the RAM for burst transfers, bounded by a fairness counter so the CPU is never starved.

## Interface
- `ADDR_W`, 10, word address width (matches RAM `addra`)
- `DATA_W`, 32, data width
- `MAX_LOCK`, 8, maximum consecutive locked cycles before the CPU is given a slot (≥2)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `cpu_req`  in  1  CPU access request; held until `cpu_gnt`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  word address
- `cpu_wdata`  in  DATA_W  write data
- `cpu_gnt`  out  1  access accepted this cycle (combinational)
- `cpu_rvalid`  out  1  `cpu_rdata` valid (registered)
- `cpu_rdata`  out  DATA_W  read data
- `cgra_req`, `cgra_we`, `cgra_addr`, `cgra_wdata`, `cgra_gnt`, `cgra_rvalid`, `cgra_rdata`: same as the CPU set, for the CGRA port
- `cgra_lock`  in  1  CGRA requests exclusive ownership; qualified by `cgra_req`
- `mem_ena`  out  1  RAM enable
- `mem_wea`  out  1  RAM write enable
- `mem_addra`  out  ADDR_W  RAM address
- `mem_dina`  out  DATA_W  RAM write data
- `mem_douta`  in  DATA_W  RAM read data, valid one cycle after a read enable

## Operation
- FSM states: ARB (reset state), LOCK, YIELD. Registers: `state`, `last_gnt` (reset = CGRA, so the first tie goes to the CPU), `lock_cnt` (reset 0), `rd_owner[1:0]` (reset 0).
- **ARB**
  - Only one requester active: grant it.
  - Both active: grant the one that is not `last_gnt`.
  - `last_gnt` updates on every grant.
  - If CGRA is granted with `cgra_lock`=1, go to LOCK with `lock_cnt`=0.
- **LOCK**
  - Only CGRA may be granted (whenever `cgra_req`=1). `cpu_gnt`=0.
  - `lock_cnt` increments every cycle, saturating at MAX_LOCK-1.
  - `cgra_lock`=0 sampled: go to ARB, `lock_cnt` cleared, `last_gnt`=CGRA.
  - Otherwise, if `lock_cnt`=MAX_LOCK-1 and `cpu_req`=1: go to YIELD.
- **YIELD**
  - Only CPU may be granted; lasts exactly one cycle, even if `cpu_req` drops.
  - Next state: LOCK (`lock_cnt`=0) if `cgra_lock`&&`cgra_req`, else ARB. `last_gnt`=CPU.
- **Grant side effects**
  - `mem_ena`=1, `mem_wea`=granted `we`, and address/data are muxed from the granted port.
  - No grant: `mem_ena`=0, `mem_wea`=0, `mem_addra`/`mem_dina` hold 0.
- **Read return**
  - A granted read sets `rd_owner` (bit0 = CPU, bit1 = CGRA) at the next edge. That drives `cpu_rvalid`/`cgra_rvalid` for exactly one cycle.
  - `*_rdata` = `mem_douta` passthrough; only meaningful while the matching rvalid is high.
  - Writes produce no rvalid.
- Back-to-back reads from either port are allowed every cycle. rvalid pulses follow grants one-to-one, in order.

## Timing
- Grant → RAM access: same cycle (0 latency). Read grant at cycle N → rvalid and data at cycle N+1.
- Reset values: `cpu_gnt`=`cgra_gnt`=0, `mem_ena`=`mem_wea`=0, `mem_addra`=`mem_dina`=0, `cpu_rvalid`=`cgra_rvalid`=0. `*_rdata` follows `mem_douta` (don't-care).
- Reset asserted mid-operation: state returns to ARB and any pending rvalid is dropped. The requester re-issues.
- Requester rules:
  - `req`/`we`/`addr`/`wdata` stay stable until `gnt`.
  - `req` may drop after `gnt`, or stay high to issue a new access next cycle.
- At most one `gnt` per cycle. `cpu_gnt`&&`cgra_gnt` never both high.
- `cgra_lock` without `cgra_req` is ignored in ARB.

## Test plan
- **Single CPU read:** after reset, `cpu_req`=1, `we`=0, `addr`=0x005, RAM[5]=0xDEADBEEF → `cpu_gnt`=1 in cycle 0, `mem_addra`=5; `cpu_rvalid`=1 with `cpu_rdata`=0xDEADBEEF in cycle 1 only.
- **Round-robin:** both ports request reads continuously from reset → grants alternate CPU, CGRA, CPU, CGRA. Each rvalid lands on the correct port one cycle after its grant.
- **Write then read:** CGRA writes 0x12345678 to 0x3FF, then CPU reads 0x3FF → `cpu_rdata`=0x12345678. No rvalid is produced for the write.
- **Lock burst:** MAX_LOCK=4, CGRA `req`+`lock` held, CPU `req` held → CGRA is granted 4 consecutive cycles (LOCK), then the CPU gets 1 cycle (YIELD), then CGRA resumes. Pattern repeats.
- **Lock release:** CGRA drops `cgra_lock` after 2 locked cycles while CPU is pending → the next cycle is ARB and the CPU is granted.
- **Reset mid-read:** assert `reset` in the cycle after a CPU read grant → `cpu_rvalid` stays 0. After reset release, ARB state and first tie goes to CPU.
